fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage that owns the PC and issues word reads to instruction memory over a req/ack handshake.
- Presents each fetched instruction and its PC to the decode stage over a valid/ready handshake.
- Supports a redirect (branch/jump target) from downstream and discards any in-flight stale fetch.
- Replaces the free-running program counter, instruction register pairing with a stall-aware, redirectable front end.

Parameters:
XLEN, 32, instruction and address width in bits
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
mem_req  output  1  instruction memory read request
mem_addr  output  XLEN  word-aligned read address, stable while mem_req=1
mem_ack  input  1  memory has returned mem_rdata this cycle
mem_rdata  input  XLEN  instruction word, valid only when mem_ack=1
instr_valid  output  1  instr_out/instr_pc hold a valid instruction
instr_ready  input  1  decode accepts the instruction this cycle
instr_out  output  XLEN  fetched instruction word
instr_pc  output  XLEN  address instr_out was fetched from
redirect_valid  input  1  load new PC this cycle
redirect_target  input  XLEN  new PC; bits [1:0] ignored (treated as 0)

Behaviour:
- Reset (async, immediate): pc=RESET_PC, req_addr=RESET_PC, state=FETCH, instr_valid=0, instr_out=0, instr_pc=0. mem_req=0 while reset is high. An abandoned memory request is the memory's concern.
- State encoding: FETCH, DRAIN, HOLD.
  - mem_req = (state==FETCH || state==DRAIN).
  - mem_addr = req_addr, a registered address.
- Handshake rule: once mem_req rises, mem_req and mem_addr stay constant until the cycle mem_ack=1. Zero-wait ack in the same cycle as the req rise is legal.
- FETCH (req_addr==pc):
  - mem_ack=1, no redirect: instr_out<=mem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+4, state<=HOLD.
  - mem_ack=1 and redirect: data discarded, pc<=req_addr<=target, stay FETCH.
  - mem_ack=0 and redirect: pc<=target, req_addr unchanged, state<=DRAIN.
  - mem_ack=0, no redirect: stay FETCH.
- DRAIN (stale request outstanding):
  - mem_ack=1: data discarded, req_addr<=pc, state<=FETCH. If redirect is also asserted, req_addr and pc take the target.
  - Redirect without ack: pc<=target, stay DRAIN.
- HOLD: instr_valid=1, mem_req=0, no prefetch.
  - instr_ready=1, no redirect: instr_valid<=0, req_addr<=pc, state<=FETCH.
  - redirect (any ready value): instr_valid<=0, pc<=req_addr<=target, state<=FETCH. The held instruction is dropped even if ready=1.
  - Otherwise: outputs held stable.
- Priority: redirect > mem_ack > instr_ready.
- Throughput: with zero-wait memory and ready held at 1, one instruction per 2 cycles.
- Arithmetic: pc+4 is modulo 2^XLEN, so 32'hFFFF_FFFC wraps to 32'h0000_0000. No error flag.
- instr_out and instr_pc change only on capture, so they stay stable throughout HOLD.

Decomposition:
- Shared package cpu_pkg holds:
  - typedef enum logic [1:0] fetch_state_t {FETCH, DRAIN, HOLD}
  - localparam INSTR_BYTES = 4
  - localparam DEFAULT_RESET_PC
  - NOP encoding 32'h0000_0013, used by benches
- No sub-module. The existing program_counter has no load/enable, so the PC is an internal register here. The register_file and ALU datapath consume instr_out downstream.

Test Plan:
- Zero-wait memory returning mem[a]=a+32'h100, instr_ready=1, 6 instructions: instr_pc sequence 0,4,8,12,16,20 with instr_out 0x100,0x104,...; instr_valid high every other cycle; mem_req never high while instr_valid=1.
- 3-cycle ack latency, instr_ready=0 for 4 cycles after first capture: mem_addr stays 0 until ack; instr_out=0x100 and instr_pc=0 held stable; no second mem_req until ready=1, then mem_addr=4.
- Redirect to 32'h40 while FETCH request to 8 is waiting (ack 2 cycles later): the ack for 8 is discarded. The next mem_req has addr 0x40, and the first delivered instr_pc=0x40 with instr_out=0x140.
- Redirect to 32'h83 during HOLD with instr_ready=1 same cycle: held instruction dropped; next fetch addr=0x80; instr_valid low for at least 1 cycle.
- RESET_PC=32'hFFFF_FFF8, zero-wait memory: instr_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Assert reset asynchronously mid-DRAIN (between clock edges): mem_req and instr_valid drop immediately. After release, the first mem_addr is RESET_PC and the stale ack is not captured.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: fetch FSM states and fetch constants.
package cpu_pkg;

  typedef enum logic [1:0] {
    FETCH,
    DRAIN,
    HOLD
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES      = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over req/ack, hands words to decode
// over valid/ready, and supports redirects that discard stale in-flight fetches.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clock,
  input  logic            reset,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr_out,
  output logic [XLEN-1:0] instr_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] out_q, out_d;
  logic [XLEN-1:0] ipc_q, ipc_d;
  logic [XLEN-1:0] target;

  assign target = redirect_target & ~XLEN'(3);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      valid_q    <= 1'b0;
      out_q      <= '0;
      ipc_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      valid_q    <= valid_d;
      out_q      <= out_d;
      ipc_q      <= ipc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    valid_d    = valid_q;
    out_d      = out_q;
    ipc_d      = ipc_q;
    case (state_q)
      FETCH: begin
        if (redirect_valid) begin
          pc_d = target;
          if (mem_ack) begin
            req_addr_d = target;
          end else begin
            // Request to the old PC is still outstanding; wait it out.
            state_d = DRAIN;
          end
        end else if (mem_ack) begin
          out_d   = mem_rdata;
          ipc_d   = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_q + XLEN'(INSTR_BYTES);
          state_d = HOLD;
        end
      end
      DRAIN: begin
        if (redirect_valid) begin
          pc_d = target;
        end
        if (mem_ack) begin
          req_addr_d = redirect_valid ? target : pc_q;
          state_d    = FETCH;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          valid_d    = 1'b0;
          pc_d       = target;
          req_addr_d = target;
          state_d    = FETCH;
        end else if (instr_ready) begin
          valid_d    = 1'b0;
          req_addr_d = pc_q;
          state_d    = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  assign mem_req     = ((state_q == FETCH) || (state_q == DRAIN)) && !reset;
  assign mem_addr    = req_addr_q;
  assign instr_valid = valid_q;
  assign instr_out   = out_q;
  assign instr_pc    = ipc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, corner-case sequences,
// and randomized traffic against a stream-level model of the delivered PCs.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_ack;
  logic [31:0] mem_addr, mem_rdata;
  logic        instr_valid, instr_ready = 1'b0;
  logic [31:0] instr_out, instr_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;

  logic        mem_req_w, instr_valid_w;
  logic [31:0] mem_addr_w, instr_out_w, instr_pc_w;

  int          lat = 0;
  int          wait_cnt = 0;
  logic        ack_force = 1'b0;
  int          checks = 0;
  int          failures = 0;

  always #5 clock = ~clock;

  assign mem_ack   = ack_force ? 1'b1 : (mem_req && (wait_cnt >= lat));
  assign mem_rdata = mem_addr + 32'h100;

  always @(posedge clock or posedge reset) begin
    if (reset) wait_cnt <= 0;
    else if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  fetch_unit dut (
    .clock(clock), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr_out(instr_out), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target)
  );

  // Second instance exercises PC wrap with a zero-wait memory and ready tied high.
  fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clock(clock), .reset(reset), .mem_req(mem_req_w), .mem_addr(mem_addr_w),
    .mem_ack(mem_req_w), .mem_rdata(mem_addr_w + 32'h100), .instr_valid(instr_valid_w),
    .instr_ready(1'b1), .instr_out(instr_out_w), .instr_pc(instr_pc_w),
    .redirect_valid(1'b0), .redirect_target(32'h0)
  );

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] tgt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_out;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // Drive inputs at a negedge, then let outputs settle for sampling.
  task automatic drive(input logic r, input logic rv, input logic [31:0] t);
    instr_ready     = r;
    redirect_valid  = rv;
    redirect_target = t;
    #1;
  endtask

  logic [31:0] exp_pc, prev_addr, prev_pc, prev_out;
  logic        prev_pend, prev_hold, acc, rv_r, rdy_r;
  int          accepts, got;
  logic [31:0] wrap_pc[4];
  logic [31:0] wrap_exp[4];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h0,  1'b0, 32'h0,  32'h0};
    tbl[1]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h0,  32'h100};
    tbl[2]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h4,  1'b0, 32'h0,  32'h100};
    tbl[3]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h4,  32'h104};
    tbl[4]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h8,  1'b0, 32'h4,  32'h104};
    tbl[5]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h8,  32'h108};
    tbl[6]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'hC,  1'b0, 32'h8,  32'h108};
    tbl[7]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'hC,  32'h10C};
    tbl[8]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h10, 1'b0, 32'hC,  32'h10C};
    tbl[9]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h10, 32'h110};
    tbl[10] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h14, 1'b0, 32'h10, 32'h110};
    tbl[11] = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h14, 32'h114};
    tbl[12] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h18, 1'b0, 32'h14, 32'h114};
    tbl[13] = '{1'b1, 1'b1, 32'h83, 1'b0, 32'h0,  1'b1, 32'h18, 32'h118};
    tbl[14] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h80, 1'b0, 32'h18, 32'h118};
    tbl[15] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h80, 32'h180};
    tbl[16] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h80, 32'h180};
    tbl[17] = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h80, 32'h180};
    tbl[18] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h84, 1'b0, 32'h80, 32'h180};
    wrap_exp[0] = 32'hFFFF_FFF8;
    wrap_exp[1] = 32'hFFFF_FFFC;
    wrap_exp[2] = 32'h0000_0000;
    wrap_exp[3] = 32'h0000_0004;

    // Zero-wait table, including the redirect-during-HOLD drop.
    lat = 0;
    do_reset();
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].rdy, tbl[i].rv, tbl[i].tgt);
      chk($sformatf("tbl%0d_req", i), {31'b0, mem_req}, {31'b0, tbl[i].e_req});
      if (tbl[i].e_req) chk($sformatf("tbl%0d_addr", i), mem_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_valid", i), {31'b0, instr_valid}, {31'b0, tbl[i].e_valid});
      chk($sformatf("tbl%0d_pc", i), instr_pc, tbl[i].e_pc);
      chk($sformatf("tbl%0d_out", i), instr_out, tbl[i].e_out);
      @(negedge clock);
    end

    // Slow memory and a stalled decode stage.
    lat = 2;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 32'h0);
      chk("lat_req", {31'b0, mem_req}, 32'h1);
      chk("lat_addr", mem_addr, 32'h0);
      @(negedge clock);
    end
    for (int i = 0; i < 5; i++) begin
      drive(i == 4, 1'b0, 32'h0);
      chk("stall_valid", {31'b0, instr_valid}, 32'h1);
      chk("stall_out", instr_out, 32'h100);
      chk("stall_pc", instr_pc, 32'h0);
      chk("stall_noreq", {31'b0, mem_req}, 32'h0);
      @(negedge clock);
    end
    drive(1'b1, 1'b0, 32'h0);
    chk("stall_next_req", {31'b0, mem_req}, 32'h1);
    chk("stall_next_addr", mem_addr, 32'h4);

    // Redirect while the fetch of 8 is waiting; its ack must be dropped.
    lat = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 32'h0);
      @(negedge clock);
    end
    lat = 2;
    drive(1'b1, 1'b1, 32'h40);
    chk("drain_addr8", mem_addr, 32'h8);
    @(negedge clock);
    drive(1'b1, 1'b0, 32'h0);
    chk("drain_hold_addr", mem_addr, 32'h8);
    @(negedge clock);
    drive(1'b1, 1'b0, 32'h0);
    chk("drain_ack_novalid", {31'b0, instr_valid}, 32'h0);
    @(negedge clock);
    lat = 0;
    drive(1'b1, 1'b0, 32'h0);
    chk("redir_addr", mem_addr, 32'h40);
    chk("redir_novalid", {31'b0, instr_valid}, 32'h0);
    @(negedge clock);
    drive(1'b1, 1'b0, 32'h0);
    chk("redir_valid", {31'b0, instr_valid}, 32'h1);
    chk("redir_pc", instr_pc, 32'h40);
    chk("redir_out", instr_out, 32'h140);
    @(negedge clock);

    // Asynchronous reset in the middle of a DRAIN.
    lat = 0;
    do_reset();
    drive(1'b0, 1'b1, 32'h200);
    @(negedge clock);
    lat = 5;
    drive(1'b0, 1'b1, 32'h300);
    @(negedge clock);
    drive(1'b0, 1'b0, 32'h0);
    chk("arst_pre_req", {31'b0, mem_req}, 32'h1);
    chk("arst_pre_addr", mem_addr, 32'h200);
    #1 reset = 1'b1;
    #1;
    chk("arst_req_drop", {31'b0, mem_req}, 32'h0);
    chk("arst_valid_drop", {31'b0, instr_valid}, 32'h0);
    ack_force = 1'b1;
    @(negedge clock);
    ack_force = 1'b0;
    lat = 2;
    reset = 1'b0;
    drive(1'b1, 1'b0, 32'h0);
    chk("arst_post_addr", mem_addr, 32'h0);
    chk("arst_post_req", {31'b0, mem_req}, 32'h1);
    chk("arst_post_valid", {31'b0, instr_valid}, 32'h0);
    chk("arst_post_out", instr_out, 32'h0);
    @(negedge clock);

    // PC wrap on the second instance.
    do_reset();
    got = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (instr_valid_w && got < 4) begin
        wrap_pc[got] = instr_pc_w;
        got++;
      end
      @(negedge clock);
    end
    chk("wrap_count", got, 4);
    for (int i = 0; i < got; i++) chk($sformatf("wrap_pc%0d", i), wrap_pc[i], wrap_exp[i]);

    // Randomized traffic vs. a stream model: each accepted instruction is the next
    // sequential PC after the last accepted one or the last redirect target.
    lat = 0;
    do_reset();
    exp_pc    = 32'h0;
    prev_pend = 1'b0;
    prev_hold = 1'b0;
    prev_addr = '0;
    prev_pc   = '0;
    prev_out  = '0;
    accepts   = 0;
    for (int c = 0; c < 4000; c++) begin
      if (wait_cnt == 0) lat = $urandom_range(0, 3);
      rv_r  = ($urandom_range(0, 9) == 0);
      rdy_r = ($urandom_range(0, 9) < 7);
      drive(rdy_r, rv_r, $urandom);
      if (prev_pend) begin
        chk("rnd_req_stable", {31'b0, mem_req}, 32'h1);
        chk("rnd_addr_stable", mem_addr, prev_addr);
      end
      if (mem_req && instr_valid) chk("rnd_req_while_valid", 32'h1, 32'h0);
      if (prev_hold) begin
        chk("rnd_hold_valid", {31'b0, instr_valid}, 32'h1);
        chk("rnd_hold_pc", instr_pc, prev_pc);
        chk("rnd_hold_out", instr_out, prev_out);
      end
      acc = instr_valid && instr_ready && !redirect_valid;
      if (acc) begin
        chk("rnd_pc", instr_pc, exp_pc);
        chk("rnd_out", instr_out, exp_pc + 32'h100);
        exp_pc = exp_pc + 32'd4;
        accepts++;
      end
      if (redirect_valid) exp_pc = redirect_target & 32'hFFFF_FFFC;
      prev_pend = mem_req && !mem_ack;
      prev_addr = mem_addr;
      prev_hold = instr_valid && !acc && !redirect_valid;
      prev_pc   = instr_pc;
      prev_out  = instr_out;
      @(negedge clock);
    end
    chk("rnd_progress", {31'b0, accepts > 200}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
